// File: rtl/truth_table_sweeper_pkg.sv
// Shared types and constants for the truth-table sweeper slice.
package tt_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRIVE  = 2'd1,
        FINISH = 2'd2
    } state_t;

    localparam int unsigned CNT_W = 16;

    function automatic int unsigned tbl_width(input int unsigned n);
        return 32'd1 << n;
    endfunction

endpackage

// File: rtl/truth_table_sweeper_dwell_counter.sv
// Dwell counter: synchronous clear-to-zero, count enable, terminal flag at DWELL-1.
module dwell_counter
    import tt_pkg::*;
#(
    parameter int unsigned DWELL = 20
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic en,
    output logic term
);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign term = (cnt == CNT_W'(DWELL - 1));

endmodule

// File: rtl/truth_table_sweeper.sv
// Sweeps all N_IN-bit input vectors through a CUT and captures its truth table.
// Optional expected-table checker enabled by defining TT_EXPECT_CHECK_EN.
module truth_table_sweeper
    import tt_pkg::*;
#(
    parameter int unsigned N_IN  = 3,
    parameter int unsigned DWELL = 20
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 y_in,
    output logic [N_IN-1:0]      vec_out,
    output logic                 busy,
    output logic                 sample_valid,
    output logic [N_IN-1:0]      sample_idx,
    output logic                 sample_y,
    output logic                 done,
    output logic [2**N_IN-1:0]   table_out
`ifdef TT_EXPECT_CHECK_EN
    ,
    input  logic [2**N_IN-1:0]   expected,
    output logic                 mismatch,
    output logic [N_IN:0]        mismatch_cnt
`endif
);

    localparam int unsigned TBL_W = tbl_width(N_IN);

    state_t state, state_nxt;
    logic   accept, capture;
    logic   cnt_clear, cnt_en, cnt_term;

    logic            cap_pend;
    logic [N_IN-1:0] cap_idx;
    logic            cap_y;

    dwell_counter #(.DWELL(DWELL)) u_dwell (
        .clk   (clk),
        .rst   (rst),
        .clear (cnt_clear),
        .en    (cnt_en),
        .term  (cnt_term)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        capture   = 1'b0;
        cnt_clear = 1'b0;
        cnt_en    = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept    = 1'b1;
                    cnt_clear = 1'b1;
                    state_nxt = DRIVE;
                end
            end
            DRIVE: begin
                if (cnt_term) begin
                    capture   = 1'b1;
                    cnt_clear = 1'b1;
                    if (vec_out == '1) begin
                        state_nxt = FINISH;
                    end
                end else begin
                    cnt_en = 1'b1;
                end
            end
            FINISH:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Captures go through a one-deep stage so the last sample pulse lines up with done.
    always_ff @(posedge clk) begin
        if (rst) begin
            vec_out      <= '0;
            busy         <= 1'b0;
            sample_valid <= 1'b0;
            sample_idx   <= '0;
            sample_y     <= 1'b0;
            done         <= 1'b0;
            table_out    <= '0;
            cap_pend     <= 1'b0;
            cap_idx      <= '0;
            cap_y        <= 1'b0;
        end else begin
            cap_pend     <= capture;
            sample_valid <= cap_pend;
            done         <= (state == FINISH);
            if (capture) begin
                cap_idx              <= vec_out;
                cap_y                <= y_in;
                table_out[vec_out]   <= y_in;
                if (vec_out != '1) begin
                    vec_out <= vec_out + 1'b1;
                end
            end
            if (cap_pend) begin
                sample_idx <= cap_idx;
                sample_y   <= cap_y;
            end
            if (accept) begin
                busy      <= 1'b1;
                vec_out   <= '0;
                table_out <= '0;
            end
            if (state == FINISH) begin
                busy <= 1'b0;
            end
        end
    end

`ifdef TT_EXPECT_CHECK_EN
    logic [TBL_W-1:0] exp_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            exp_q        <= '0;
            mismatch     <= 1'b0;
            mismatch_cnt <= '0;
        end else if (accept) begin
            exp_q        <= expected;
            mismatch     <= 1'b0;
            mismatch_cnt <= '0;
        end else if (capture && (y_in != exp_q[vec_out])) begin
            mismatch     <= 1'b1;
            mismatch_cnt <= mismatch_cnt + 1'b1;
        end
    end
`else
    // Without the checker the sweep logic above is the whole design.
`endif

endmodule

// File: doc/truth_table_sweeper.md
Name: truth_table_sweeper

Overview:
- Sequential stimulus-and-capture stage wrapped around a small N-input combinational circuit under test (CUT).
- Drives every input combination onto the CUT inputs in ascending binary order and holds each one for a fixed dwell.
- Samples the CUT output at the end of each dwell and assembles the full truth table as a packed word.
- Replaces hand-written per-vector stimulus with a synthesizable sweep that on-board logic or a bench can read back.

Parameters:
- N_IN, 3, number of CUT inputs (1..8); the truth table is 2**N_IN bits wide.
- DWELL, 20, clock cycles each vector is held before sampling (legal range 1..65535).

Ports:
- clk  in  1  single clock, rising-edge active.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request to begin a sweep; only accepted in IDLE.
- y_in  in  1  CUT output.
- vec_out  out  N_IN  CUT input vector; MSB drives the first CUT input (A), LSB the last (C).
- busy  out  1  high while a sweep is in progress.
- sample_valid  out  1  one-cycle pulse, the cycle after each capture.
- sample_idx  out  N_IN  vector index of the latest capture; valid with sample_valid.
- sample_y  out  1  captured y_in value; valid with sample_valid.
- done  out  1  one-cycle pulse when the sweep completes.
- table_out  out  2**N_IN  captured truth table; bit i = y_in observed for vector i.

Behaviour:
- Reset state, synchronous on a clk edge with rst=1: FSM=IDLE and every output 0 (vec_out, busy, sample_valid, sample_idx, sample_y, done, table_out). Dwell counter = 0.
- FSM states: IDLE, DRIVE, FINISH. All outputs are registered.
- IDLE, start=1 at edge k:
  - Go to DRIVE; busy=1, vec_out=0, cnt=0, table_out cleared to 0.
  - vec_out=0 is visible from the cycle after edge k.
- DRIVE, on each edge:
  - If cnt<DWELL-1: cnt increments.
  - If cnt==DWELL-1: table_out[vec_out] <= y_in. Next cycle: sample_valid=1, sample_idx=old vec_out, sample_y=captured value.
  - If vec_out<2**N_IN-1: vec_out increments and cnt=0.
  - Else: go to FINISH and hold vec_out at its final value.
- FINISH, for exactly one cycle: done=1, busy=0, then return to IDLE.
  - The final sample_valid pulse and done occur in the same cycle.
  - table_out holds its value until the next accepted start or rst.
- Latency: done is high in the cycle beginning (2**N_IN)*DWELL+1 edges after the start edge. With the defaults, that is the cycle after edge k+161.
- Each vector is presented for exactly DWELL cycles, and y_in is sampled on the last edge of each dwell. The CUT has DWELL-1 cycles to settle.
- Boundary conditions:
  - start in DRIVE or FINISH is ignored; no restart and no queuing.
  - start and rst high together: rst wins.
  - rst mid-sweep: immediate return to IDLE with all outputs 0; the partial table is discarded.
  - DWELL=1: the vector advances every cycle and sample_valid is high on consecutive cycles.
  - vec_out never wraps past 2**N_IN-1 within a sweep.
  - Counter width is 16 bits; the vector index width is N_IN.

Optional Feature:
- Macro: TT_EXPECT_CHECK_EN.
- Defined:
  - Adds input expected (2**N_IN bits, sampled at the accepted start).
  - Adds output mismatch (1 bit) and output mismatch_cnt (N_IN+1 bits), both cleared on start and on rst.
  - Each capture compares y_in with expected[vec_out]. On a difference, mismatch_cnt increments and mismatch is set sticky until the next start or rst.
  - Both outputs are final at done.
- Undefined: those ports and that logic do not exist; all other behaviour is identical.

Decomposition:
- Shared package tt_pkg:
  - state encoding IDLE=2'd0, DRIVE=2'd1, FINISH=2'd2;
  - constant CNT_W=16;
  - a function giving the table width 2**n.
- One natural sub-module, dwell_counter: load-to-zero, increment-enable, terminal flag at DWELL-1. It is reused by the sweep FSM.

Test Plan:
- Majority CUT (Y = AB+BC+AC), DWELL=20, start pulse -> vec_out steps 0..7, 20 cycles each; table_out=8'b1110_1000; done high exactly one cycle at start edge+161; busy falls in the same cycle.
- AND3 CUT, DWELL=1 -> sample_valid high 8 consecutive cycles with sample_idx 0..7; sample_y=1 only at idx 7; table_out=8'h80.
- XOR3 CUT; start re-pulsed at cycles +5 and +100 -> both ignored; a single sweep completes; table_out=8'b1001_0110.
- rst asserted at cycle +50 of a sweep -> next cycle all outputs 0 and FSM in IDLE; a new start then produces a full correct sweep.
- start and rst high on the same edge -> IDLE with outputs 0, no sweep begins.
- With TT_EXPECT_CHECK_EN, majority CUT, expected=8'b1110_1001 -> mismatch=1 and mismatch_cnt=1 at done; with expected=8'b1110_1000, both are 0.
